// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM round-robin arbiter.
// Holds the lock-state encoding and the byte-enable to bit-enable expansion.
package sram_arb_pkg;

    localparam int MAX_PORTS      = 8;
    localparam int MAX_DATA_WIDTH = 512;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Each byte enable becomes eight identical bit enables; callers slice the low DATA_WIDTH bits.
    function automatic logic [MAX_DATA_WIDTH-1:0] be2bitmask(input logic [MAX_DATA_WIDTH/8-1:0] be);
        logic [MAX_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DATA_WIDTH/8; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: per-port req/gnt handshake plus broadcast response.
// master = requester side, slave = arbiter side.
interface sram_rr_arbiter_if #(
    parameter int NR_PORTS   = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [NR_PORTS-1:0]              req_i;
    logic [NR_PORTS-1:0]              we_i;
    logic [NR_PORTS*ADDR_WIDTH-1:0]   addr_i;
    logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i;
    logic [NR_PORTS*DATA_WIDTH-1:0]   wdata_i;
    logic [NR_PORTS-1:0]              lock_i;
    logic [NR_PORTS-1:0]              gnt_o;
    logic [NR_PORTS-1:0]              rvalid_o;
    logic [DATA_WIDTH-1:0]            rdata_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i, lock_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i, lock_i,
        output gnt_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping, via a double-width search.
// Latency: purely combinational.
// Backpressure: none; a zero request vector yields vld=0 and an all-zero grant.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    logic [2*N-1:0] dbl;

    // Concatenating req with itself turns the wrap-around search into a linear scan from ptr.
    always_comb begin
        dbl = {req, req};
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            if (!vld && (i >= int'(ptr)) && dbl[i]) begin
                vld = 1'b1;
                idx = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
            end
        end
        gnt[idx] = vld;
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NR_PORTS requesters (optional lock: SRAM_ARB_LOCK_EN).
// Latency: grant same cycle as req, rvalid/rdata exactly one cycle after grant; 1 access/cycle.
// Backpressure: losers are simply not granted and must hold req and fields until gnt.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NR_PORTS   = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    sram_rr_arbiter_if.slave      port_if,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    if (NR_PORTS < 2 || NR_PORTS > MAX_PORTS) begin : g_bad_ports
        $error("sram_rr_arbiter: NR_PORTS out of range");
    end
    if (MAX_LOCK < 1) begin : g_bad_lock
        $error("sram_rr_arbiter: MAX_LOCK must be at least 1");
    end
    if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("sram_rr_arbiter: DATA_WIDTH too large");
    end

    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    ptr_next;
    logic [IDX_W-1:0]    win_idx;
    logic [NR_PORTS-1:0] req_eff;
    logic [NR_PORTS-1:0] gnt;
    logic [NR_PORTS-1:0] resp_q;
    logic                gnt_vld;
    logic                lock_hold;

    rr_pick #(
        .N     (NR_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (req_eff),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx),
        .vld (gnt_vld)
    );

    assign ptr_next = (win_idx == IDX_W'(NR_PORTS - 1)) ? '0 : win_idx + 1'b1;

`ifdef SRAM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_LOCKED = LOCKED;

    logic [0:0]          lock_state_q;
    logic [IDX_W-1:0]    lock_owner_q;
    logic [CNT_W-1:0]    lock_cnt_q;
    logic [NR_PORTS-1:0] owner_mask;

    always_comb begin
        owner_mask = '0;
        owner_mask[lock_owner_q] = 1'b1;
    end

    // Release is seen in the same cycle it happens, so that cycle is already a normal arbitration.
    assign lock_hold = (lock_state_q == ST_LOCKED) && port_if.lock_i[lock_owner_q]
                       && (lock_cnt_q < CNT_W'(MAX_LOCK));
    assign req_eff   = lock_hold ? (port_if.req_i & owner_mask) : port_if.req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_state_q <= ST_IDLE;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
        end else if (lock_hold) begin
            if (gnt_vld) begin
                lock_cnt_q <= lock_cnt_q + 1'b1;
            end
        end else if (gnt_vld && port_if.lock_i[win_idx]) begin
            lock_state_q <= ST_LOCKED;
            lock_owner_q <= win_idx;
            lock_cnt_q   <= CNT_W'(1);
        end else begin
            lock_state_q <= ST_IDLE;
            lock_cnt_q   <= '0;
        end
    end
`else
    logic [NR_PORTS-1:0] unused_lock;

    assign unused_lock = port_if.lock_i;
    assign lock_hold   = 1'b0;
    assign req_eff     = port_if.req_i;
`endif

    // The pointer only moves on unlocked grants; the lock-entry grant already leaves it at owner+1,
    // which makes a forced release hand the owner lowest priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
            resp_q <= '0;
        end else begin
            resp_q <= gnt;
            if (gnt_vld && !lock_hold) begin
                rr_ptr <= ptr_next;
            end
        end
    end

    assign port_if.gnt_o    = gnt;
    assign port_if.rvalid_o = resp_q;
    assign port_if.rdata_o  = mem_rdata_i;

    logic [BE_W-1:0]             sel_be;
    logic [MAX_DATA_WIDTH/8-1:0] be_ext;
    logic [MAX_DATA_WIDTH-1:0]   mask_full;

    always_comb begin
        sel_be      = port_if.be_i[win_idx*BE_W +: BE_W];
        be_ext      = '0;
        be_ext[BE_W-1:0] = sel_be;
        mask_full   = be2bitmask(be_ext);
        mem_req_o   = gnt_vld;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (gnt_vld) begin
            mem_we_o    = port_if.we_i[win_idx];
            mem_addr_o  = port_if.addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_be_o    = mask_full[DATA_WIDTH-1:0];
            mem_wdata_o = port_if.wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule
